// File: rtl/calc_pkg.sv
// Shared types and seven-segment constants for the calculator display engine.
// Segment patterns are {g,f,e,d,c,b,a}, active-low.
package calc_pkg;

  typedef enum logic [1:0] {
    OPC_ADD  = 2'b00,
    OPC_SUB  = 2'b01,
    OPC_MUL  = 2'b10,
    OPC_PASS = 2'b11
  } opcode_e;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CALC,
    ST_CONV,
    ST_LOAD
  } state_e;

  localparam logic [6:0] SEG_BLANK = 7'h7F;
  localparam logic [6:0] SEG_MINUS = 7'b0111111;
  localparam logic [6:0] SEG_E     = 7'b0000110;

  function automatic logic [6:0] seg_digit(input logic [3:0] d);
    logic [6:0] p;
    case (d)
      4'd0:    p = 7'b1000000;
      4'd1:    p = 7'b1111001;
      4'd2:    p = 7'b0100100;
      4'd3:    p = 7'b0110000;
      4'd4:    p = 7'b0011001;
      4'd5:    p = 7'b0010010;
      4'd6:    p = 7'b0000010;
      4'd7:    p = 7'b1111000;
      4'd8:    p = 7'b0000000;
      4'd9:    p = 7'b0010000;
      default: p = SEG_BLANK;
    endcase
    return p;
  endfunction

  function automatic longint unsigned pow10(input int unsigned n);
    longint unsigned p;
    p = 1;
    for (int unsigned i = 0; i < n; i++) p = p * 10;
    return p;
  endfunction

endpackage

// File: rtl/calc_display_engine_seg_scan_mux.sv
// Multiplexed seven-segment scanner: cycles a one-hot active-low digit enable
// and presents the matching digit pattern, both registered on the same edge.
module seg_scan_mux
  import calc_pkg::*;
#(
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic [NUM_DIGITS-1:0][6:0] digits,
  output logic [6:0]                 segBits,
  output logic [NUM_DIGITS-1:0]      trigger
);

  localparam int unsigned CW = (REFRESH_DIV > 1) ? $clog2(REFRESH_DIV) : 1;
  localparam int unsigned IW = $clog2(NUM_DIGITS);

  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [IW-1:0] idx_nxt;
  logic          wrap;

  always_comb begin
    wrap    = (cnt == CW'(REFRESH_DIV - 1));
    idx_nxt = idx;
    if (wrap) idx_nxt = (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + IW'(1);
  end

  // Outputs follow the next index so trigger/segBits line up with idx itself.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt     <= '0;
      idx     <= '0;
      trigger <= ~NUM_DIGITS'(1);
      segBits <= SEG_BLANK;
    end else begin
      cnt     <= wrap ? '0 : cnt + CW'(1);
      idx     <= idx_nxt;
      trigger <= ~(NUM_DIGITS'(1) << idx_nxt);
      segBits <= digits[idx_nxt];
    end
  end

endmodule

// File: rtl/calc_display_engine.sv
// Sequential calculator: computes op1 <opcode> op2, converts the magnitude to
// BCD one bit per clock, and drives a scanned seven-segment display.
module calc_display_engine
  import calc_pkg::*;
#(
  parameter int unsigned OP_W        = 4,
  parameter int unsigned NUM_DIGITS  = 4,
  parameter int unsigned REFRESH_DIV = 50000
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  start,
  input  logic [OP_W-1:0]       op1,
  input  logic [OP_W-1:0]       op2,
  input  logic [1:0]            opcode,
  input  logic                  sign,
  output logic                  busy,
  output logic                  done,
  output logic                  err,
  output logic [6:0]            segBits,
  output logic [NUM_DIGITS-1:0] trigger
);

  localparam int unsigned MAG_W = 2 * OP_W;
  localparam int unsigned RW    = MAG_W + 2;
  localparam int unsigned BW    = 4 * NUM_DIGITS;
  localparam int unsigned CW    = $clog2(MAG_W + 1);
  localparam longint unsigned LIM_POS = pow10(NUM_DIGITS);
  localparam longint unsigned LIM_NEG = pow10(NUM_DIGITS - 1);

  state_e state;
  state_e state_nxt;

  logic [OP_W-1:0]  op1_q;
  logic [OP_W-1:0]  op2_q;
  opcode_e          opc_q;
  logic             sign_q;
  logic             neg_q;
  logic             ovf_q;
  logic [MAG_W-1:0] mag_sr;
  logic [BW-1:0]    bcd;
  logic [CW-1:0]    cnt;
  logic             done_q;
  logic             err_q;

  logic [NUM_DIGITS-1:0][6:0] disp;
  logic [NUM_DIGITS-1:0][6:0] disp_nxt;

  logic [RW-1:0]    a_ext;
  logic [RW-1:0]    b_ext;
  logic [RW-1:0]    res;
  logic             res_neg;
  logic [MAG_W-1:0] res_mag;
  logic             res_ovf;
  logic [BW-1:0]    bcd_adj;

  // Full-precision arithmetic in RW bits; every opcode's true result fits.
  always_comb begin
    a_ext = {{(RW - OP_W){sign_q & op1_q[OP_W-1]}}, op1_q};
    b_ext = {{(RW - OP_W){sign_q & op2_q[OP_W-1]}}, op2_q};
    unique case (opc_q)
      OPC_ADD:  res = a_ext + b_ext;
      OPC_SUB:  res = a_ext - b_ext;
      OPC_MUL:  res = a_ext * b_ext;
      OPC_PASS: res = a_ext;
      default:  res = a_ext;
    endcase
    res_neg = res[RW-1];
    res_mag = MAG_W'(res_neg ? (~res + RW'(1)) : res);
    res_ovf = (64'(res_mag) >= (res_neg ? LIM_NEG : LIM_POS));
  end

  always_comb begin
    bcd_adj = bcd;
    for (int unsigned i = 0; i < NUM_DIGITS; i++) begin
      if (bcd[4*i +: 4] >= 4'd5) bcd_adj[4*i +: 4] = bcd[4*i +: 4] + 4'd3;
    end
  end

  // Scan from the most significant digit, blanking zeros until the first
  // non-zero digit; digit 0 is always shown.
  always_comb begin
    logic       lead;
    logic [3:0] d;
    disp_nxt = {NUM_DIGITS{SEG_BLANK}};
    lead     = 1'b1;
    d        = '0;
    for (int unsigned k = 0; k < NUM_DIGITS; k++) begin
      d = bcd[4*(NUM_DIGITS-1-k) +: 4];
      if (!(lead && (d == 4'd0) && (k != NUM_DIGITS - 1))) begin
        lead = 1'b0;
        disp_nxt[NUM_DIGITS-1-k] = seg_digit(d);
      end
    end
    if (neg_q) disp_nxt[NUM_DIGITS-1] = SEG_MINUS;
    if (ovf_q) begin
      disp_nxt    = {NUM_DIGITS{SEG_BLANK}};
      disp_nxt[0] = SEG_E;
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ST_IDLE: if (start) state_nxt = ST_CALC;
      ST_CALC: state_nxt = ST_CONV;
      ST_CONV: if (cnt == CW'(1)) state_nxt = ST_LOAD;
      ST_LOAD: state_nxt = ST_IDLE;
      default: state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) state <= ST_IDLE;
    else     state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op1_q  <= '0;
      op2_q  <= '0;
      opc_q  <= OPC_ADD;
      sign_q <= 1'b0;
      neg_q  <= 1'b0;
      ovf_q  <= 1'b0;
      mag_sr <= '0;
      bcd    <= '0;
      cnt    <= '0;
      done_q <= 1'b0;
      err_q  <= 1'b0;
      disp   <= {NUM_DIGITS{SEG_BLANK}};
    end else begin
      done_q <= (state == ST_LOAD);
      unique case (state)
        ST_IDLE: begin
          if (start) begin
            op1_q  <= op1;
            op2_q  <= op2;
            opc_q  <= opcode_e'(opcode);
            sign_q <= sign;
          end
        end
        ST_CALC: begin
          neg_q  <= res_neg;
          ovf_q  <= res_ovf;
          mag_sr <= res_mag;
          bcd    <= '0;
          cnt    <= CW'(MAG_W);
        end
        ST_CONV: begin
          bcd    <= BW'({bcd_adj, mag_sr[MAG_W-1]});
          mag_sr <= {mag_sr[MAG_W-2:0], 1'b0};
          cnt    <= cnt - CW'(1);
        end
        ST_LOAD: begin
          disp  <= disp_nxt;
          err_q <= ovf_q;
        end
        default: ;
      endcase
    end
  end

  assign busy = (state != ST_IDLE);
  assign done = done_q;
  assign err  = err_q;

  seg_scan_mux #(
    .NUM_DIGITS (NUM_DIGITS),
    .REFRESH_DIV(REFRESH_DIV)
  ) u_scan (
    .clk    (clk),
    .rst    (rst),
    .digits (disp),
    .segBits(segBits),
    .trigger(trigger)
  );

endmodule

// File: tb/tb_calc_display_engine.sv
// Self-checking bench for calc_display_engine: two instances (4-bit and 8-bit
// operands) compared against an integer-arithmetic reference model.
module tb_calc_display_engine;

  localparam int N   = 4;
  localparam int DIV = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start = 1'b0;
  logic       sign = 1'b0;
  logic       sel = 1'b0;
  logic [1:0] opcode = 2'b00;
  logic [7:0] op1 = 8'd0;
  logic [7:0] op2 = 8'd0;

  logic       busy4, done4, err4, busy8, done8, err8;
  logic [6:0] seg4, seg8;
  logic [3:0] trig4, trig8;
  logic       start4, start8;
  logic       busy, done, err;
  logic [6:0] seg;
  logic [3:0] trig;

  assign start4 = start & ~sel;
  assign start8 = start & sel;
  assign busy   = sel ? busy8 : busy4;
  assign done   = sel ? done8 : done4;
  assign err    = sel ? err8  : err4;
  assign seg    = sel ? seg8  : seg4;
  assign trig   = sel ? trig8 : trig4;

  calc_display_engine #(.OP_W(4), .NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut4 (
    .clk(clk), .rst(rst), .start(start4), .op1(op1[3:0]), .op2(op2[3:0]),
    .opcode(opcode), .sign(sign), .busy(busy4), .done(done4), .err(err4),
    .segBits(seg4), .trigger(trig4)
  );

  calc_display_engine #(.OP_W(8), .NUM_DIGITS(N), .REFRESH_DIV(DIV)) dut8 (
    .clk(clk), .rst(rst), .start(start8), .op1(op1), .op2(op2),
    .opcode(opcode), .sign(sign), .busy(busy8), .done(done8), .err(err8),
    .segBits(seg8), .trigger(trig8)
  );

  always #5 clk = ~clk;

  // Edges since the last reset edge; the scan position follows directly from it.
  int unsigned scan_n = 0;
  always @(posedge clk) begin
    if (rst) scan_n <= 0;
    else     scan_n <= scan_n + 1;
  end

  int         n_cmp = 0;
  int         n_bad = 0;
  logic [6:0] exp_pat [N];
  logic       exp_err;

  function automatic logic [6:0] digit_seg(input longint d);
    case (d)
      0: return 7'b1000000;
      1: return 7'b1111001;
      2: return 7'b0100100;
      3: return 7'b0110000;
      4: return 7'b0011001;
      5: return 7'b0010010;
      6: return 7'b0000010;
      7: return 7'b1111000;
      8: return 7'b0000000;
      9: return 7'b0010000;
      default: return 7'bxxxxxxx;
    endcase
  endfunction

  task automatic model(input bit w8, input bit sg, input logic [1:0] opc,
                       input logic [7:0] x, input logic [7:0] y);
    int     w;
    longint a, b, r, m, lim, pw;
    int     top;
    w = w8 ? 8 : 4;
    a = w8 ? longint'(x) : longint'(x[3:0]);
    b = w8 ? longint'(y) : longint'(y[3:0]);
    if (sg && a >= (longint'(1) << (w - 1))) a -= (longint'(1) << w);
    if (sg && b >= (longint'(1) << (w - 1))) b -= (longint'(1) << w);
    case (opc)
      2'd0:    r = a + b;
      2'd1:    r = a - b;
      2'd2:    r = a * b;
      default: r = a;
    endcase
    m   = (r < 0) ? -r : r;
    lim = (r < 0) ? 1000 : 10000;
    for (int i = 0; i < N; i++) exp_pat[i] = 7'h7F;
    if (m >= lim) begin
      exp_err    = 1'b1;
      exp_pat[0] = 7'b0000110;
    end else begin
      exp_err = 1'b0;
      top = 0;
      pw  = 1;
      for (int i = 0; i < N; i++) begin
        if ((m / pw) % 10 != 0) top = i;
        pw = pw * 10;
      end
      pw = 1;
      for (int i = 0; i <= top; i++) begin
        exp_pat[i] = digit_seg((m / pw) % 10);
        pw = pw * 10;
      end
      if (r < 0) exp_pat[N-1] = 7'b0111111;
    end
  endtask

  task automatic check_display(input string tag);
    int          idx;
    logic [3:0]  et;
    for (int c = 0; c < N * DIV; c++) begin
      @(negedge clk);
      idx = int'((scan_n / DIV) % N);
      et  = ~(4'b0001 << idx);
      n_cmp++;
      if (trig !== et) begin
        n_bad++;
        $display("FAIL %s trigger: got %b expected %b", tag, trig, et);
      end
      n_cmp++;
      if (seg !== exp_pat[idx]) begin
        n_bad++;
        $display("FAIL %s digit%0d: got %b expected %b", tag, idx, seg, exp_pat[idx]);
      end
    end
  endtask

  task automatic run_op(input bit w8, input bit sg, input logic [1:0] opc,
                        input logic [7:0] x, input logic [7:0] y, input string tag);
    int k;
    int lat;
    model(w8, sg, opc, x, y);
    lat = w8 ? 18 : 10;
    @(negedge clk);
    sel = w8; sign = sg; opcode = opc; op1 = x; op2 = y; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    n_cmp++;
    if (busy !== 1'b1) begin
      n_bad++;
      $display("FAIL %s busy: got %b expected 1", tag, busy);
    end
    k = 0;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k !== lat) begin
      n_bad++;
      $display("FAIL %s latency: got %0d expected %0d", tag, k, lat);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_bad++;
      $display("FAIL %s err: got %b expected %b", tag, err, exp_err);
    end
    @(negedge clk);
    n_cmp++;
    if (done !== 1'b0 || busy !== 1'b0) begin
      n_bad++;
      $display("FAIL %s after_done: got done=%b busy=%b expected 0 0", tag, done, busy);
    end
    check_display(tag);
  endtask

  task automatic test_reset();
    rst = 1'b1;
    repeat (3) @(negedge clk);
    n_cmp++;
    if ({busy, done, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset flags: got %b expected 000", {busy, done, err});
    end
    n_cmp++;
    if (trig !== 4'b1110) begin
      n_bad++;
      $display("FAIL reset trigger: got %b expected 1110", trig);
    end
    n_cmp++;
    if (seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL reset seg: got %b expected 1111111", seg);
    end
    rst = 1'b0;
    for (int i = 0; i < N; i++) exp_pat[i] = 7'h7F;
    check_display("reset_scan");
  endtask

  task automatic test_directed();
    run_op(1'b0, 1'b0, 2'd0, 8'd9, 8'd7, "add_9_7");
    run_op(1'b0, 1'b1, 2'd2, 8'h08, 8'h08, "smul_m8_m8");
    run_op(1'b0, 1'b1, 2'd0, 8'h0D, 8'h00, "sadd_m3_0");
    run_op(1'b0, 1'b0, 2'd1, 8'd3, 8'd5, "usub_3_5");
    run_op(1'b0, 1'b0, 2'd3, 8'd0, 8'd9, "pass_0");
    run_op(1'b1, 1'b0, 2'd2, 8'd255, 8'd255, "mul_255_ovf");
    run_op(1'b1, 1'b1, 2'd1, 8'h80, 8'h7F, "ssub_m128_127");
    run_op(1'b1, 1'b0, 2'd2, 8'd99, 8'd101, "mul_9999");
  endtask

  task automatic test_random();
    for (int i = 0; i < 20; i++) begin
      run_op(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             2'($urandom_range(0, 3)), 8'($urandom), 8'($urandom), "random");
    end
  endtask

  task automatic test_start_during_busy();
    int   pulses;
    logic prev_err;
    prev_err = exp_err;
    model(1'b0, 1'b0, 2'd2, 8'd6, 8'd7);
    @(negedge clk);
    sel = 1'b0; sign = 1'b0; opcode = 2'd2; op1 = 8'd6; op2 = 8'd7; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    n_cmp++;
    if (err !== prev_err) begin
      n_bad++;
      $display("FAIL busy_restart err_hold: got %b expected %b", err, prev_err);
    end
    opcode = 2'd0; op1 = 8'd1; op2 = 8'd1; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    pulses = 0;
    for (int c = 0; c < 30; c++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 1) begin
      n_bad++;
      $display("FAIL busy_restart pulses: got %0d expected 1", pulses);
    end
    n_cmp++;
    if (err !== exp_err) begin
      n_bad++;
      $display("FAIL busy_restart err: got %b expected %b", err, exp_err);
    end
    check_display("busy_restart");
  endtask

  task automatic test_reset_mid();
    int pulses;
    @(negedge clk);
    sel = 1'b0; sign = 1'b0; opcode = 2'd2; op1 = 8'd9; op2 = 8'd9; start = 1'b1;
    @(negedge clk);
    start = 1'b0;
    repeat (4) @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    n_cmp++;
    if ({busy, done, err} !== 3'b000) begin
      n_bad++;
      $display("FAIL reset_mid flags: got %b expected 000", {busy, done, err});
    end
    n_cmp++;
    if (trig !== 4'b1110 || seg !== 7'h7F) begin
      n_bad++;
      $display("FAIL reset_mid outputs: got %b/%b expected 1110/1111111", trig, seg);
    end
    pulses = 0;
    for (int c = 0; c < 20; c++) begin
      @(negedge clk);
      if (done === 1'b1) pulses++;
    end
    n_cmp++;
    if (pulses !== 0) begin
      n_bad++;
      $display("FAIL reset_mid pulses: got %0d expected 0", pulses);
    end
    for (int i = 0; i < N; i++) exp_pat[i] = 7'h7F;
    check_display("reset_mid_blank");
    run_op(1'b0, 1'b0, 2'd0, 8'd5, 8'd6, "after_reset");
  endtask

  task automatic test_start_held();
    int k;
    model(1'b0, 1'b0, 2'd0, 8'd2, 8'd3);
    @(negedge clk);
    sel = 1'b0; sign = 1'b0; opcode = 2'd0; op1 = 8'd2; op2 = 8'd3; start = 1'b1;
    k = -1;
    while (done !== 1'b1 && k < 40) begin
      @(negedge clk);
      k++;
    end
    n_cmp++;
    if (k !== 10) begin
      n_bad++;
      $display("FAIL held first_latency: got %0d expected 10", k);
    end
    k = 0;
    do begin
      @(negedge clk);
      k++;
    end while (done !== 1'b1 && k < 40);
    start = 1'b0;
    n_cmp++;
    if (k !== 11) begin
      n_bad++;
      $display("FAIL held second_latency: got %0d expected 11", k);
    end
    repeat (2) @(negedge clk);
    n_cmp++;
    if (busy !== 1'b0) begin
      n_bad++;
      $display("FAIL held idle_after: got busy=%b expected 0", busy);
    end
    check_display("held");
  endtask

  initial begin
    test_reset();
    test_directed();
    test_random();
    test_start_during_busy();
    test_reset_mid();
    test_start_held();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/calc_display_engine.md
Name: calc_display_engine

Overview:
Parametrised, sequential successor to the single-shot 4-bit calculator datapath.
- Accepts two OP_W-bit operands and a 2-bit opcode under a start/busy/done handshake.
- Computes and registers the result, then converts its magnitude to BCD with an iterative shift-add-3 (one bit per clock).
- Drives a NUM_DIGITS-digit multiplexed seven-segment display with sign, leading-zero blanking and overflow indication.
- Sits between the board switch/button inputs and the display pins.

Parameters:
OP_W, 4, operand width in bits (>=2)
NUM_DIGITS, 4, number of display digits (2..8)
REFRESH_DIV, 50000, clock cycles each digit stays enabled during scanning (>=1)

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
start  in  1  request; sampled only in IDLE
op1  in  OP_W  operand 1
op2  in  OP_W  operand 2
opcode  in  2  00 add, 01 sub (op1-op2), 10 mul, 11 pass op1
sign  in  1  1 = operands two's complement, 0 = unsigned; sampled with start
busy  out  1  high from the cycle after start is accepted until done
done  out  1  one-cycle pulse when the display value updates
err  out  1  high while the displayed value is an overflow indication
segBits  out  7  {g,f,e,d,c,b,a}, active-low
trigger  out  NUM_DIGITS  digit enables, one-hot active-low; bit 0 is the rightmost digit

Behaviour:
- Widths and limits:
  - MAG_W = 2*OP_W (magnitude width).
  - LIMIT = 10^(NUM_DIGITS-1) for negative results, 10^NUM_DIGITS for non-negative results; constant at elaboration.
- Reset: FSM to IDLE; busy=0, done=0, err=0; all display digit registers blank; scan index=0; refresh counter=0; trigger=~1 (digit 0 enabled); segBits=7'h7F.
- FSM states:
  - IDLE: when start=1, latch op1/op2/opcode/sign, go to CALC.
  - CALC (1 cycle): compute the full-precision signed result, with operands sign- or zero-extended per sign. Store the sign flag and the MAG_W-bit magnitude. Load the shift counter with MAG_W. Go to CONV.
  - CONV (MAG_W cycles): one double-dabble shift per cycle into the NUM_DIGITS BCD registers. Go to LOAD when the counter reaches 0.
  - LOAD (1 cycle): update the display registers, assert done for this cycle, go to IDLE.
- Latency: done is high exactly MAG_W+2 cycles after the edge that sampled start. busy is high throughout CALC/CONV/LOAD and low in the done cycle's successor.
- start while busy: ignored; no queuing.
- start held high: a new operation begins in the cycle after returning to IDLE.
- Subtraction in unsigned mode with op1<op2 yields a negative result, displayed with a sign.
- Display content written in LOAD:
  - Overflow (magnitude >= LIMIT): err=1. Digit 0 shows 'E' (7'b0000110); all other digits are blank.
  - Otherwise: err=0. Digits hold BCD, with leading zeros blanked; digit 0 always shows a value, so 0 displays as "0".
  - Negative result: digit NUM_DIGITS-1 shows '-' (7'b0111111). Negative zero cannot occur.
- Display registers and err hold their value across CALC/CONV; they change only in LOAD or on reset.
- Scan:
  - The refresh counter runs continuously, independent of the FSM.
  - When it reaches REFRESH_DIV-1 it wraps to 0 and the scan index advances, wrapping from NUM_DIGITS-1 to 0.
  - trigger = ~(1<<index); segBits = the pattern of the indexed digit.
  - Outputs are registered, so segBits and trigger change on the same edge.
- Reset mid-operation: FSM returns to IDLE and the display blanks; no done pulse occurs for the aborted operation.

Decomposition:
- Package calc_pkg holds:
  - opcode enum (OPC_ADD, OPC_SUB, OPC_MUL, OPC_PASS)
  - FSM state enum (ST_IDLE, ST_CALC, ST_CONV, ST_LOAD)
  - segment constants SEG_BLANK, SEG_MINUS, SEG_E, and the digit 0-9 pattern function
- One sub-module, seg_scan_mux (params NUM_DIGITS, REFRESH_DIV): refresh counter, scan index, and registered trigger/segBits from an array of 7-bit digit patterns.

Test Plan:
- OP_W=4, NUM_DIGITS=4, REFRESH_DIV=4, unsigned: 9+7 with start pulse -> done exactly 10 cycles later. Digits (3..0) = blank, blank, '1', '6'; err=0. trigger sequence 1110, 1101, 1011, 0111, with each value held 4 cycles.
- Signed mode, op1=4'b1000, op2=4'b1000, mul (-8 * -8) -> digits blank, blank, '6', '4'. Then signed 4'b1101 + 4'b0000 (-3+0) -> digits '-', blank, blank, '3'.
- Unsigned sub 3-5 -> '-', blank, blank, '2'. Then pass op1=0 -> blank, blank, blank, '0'.
- OP_W=8, NUM_DIGITS=4: unsigned 255*255=65025 -> err=1, digit 0 = 7'b0000110, others 7'h7F, done after 18 cycles.
- Start re-pulsed during CONV with different operands -> ignored; exactly one done pulse, and it reflects the first operands.
- rst asserted mid-CONV -> next cycle busy=0, all digits blank, no done. A following start completes normally.
